// File: rtl/replica_pkg.sv
// Shared types and constants for the parallel-tempering replica array.
// Exchange scheduler FSM state encoding and statistics counter width.
package replica_pkg;

  typedef enum logic [1:0] {
    EX_IDLE   = 2'd0,
    EX_ISSUE  = 2'd1,
    EX_COMMIT = 2'd2
  } exch_state_t;

  localparam int EXCH_CNT_W = 16;

endpackage

// File: rtl/exchange_stat.sv
// Saturating accepted-swap counter with synchronous clear.
// Clear wins over an increment arriving in the same cycle.
module exchange_stat
  import replica_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  output logic [EXCH_CNT_W-1:0] count
);

  // Count accepted swaps, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {EXCH_CNT_W{1'b1}})) begin
      count <= count + EXCH_CNT_W'(1);
    end
  end

endmodule

// File: rtl/exchange_scheduler.sv
// Replica-exchange sequencer: after each annealing cycle it walks the
// neighbouring replica pairs of the current parity through the shared
// Metropolis judge, then applies all accepted swaps in one COMMIT cycle.
// Parity alternates between even pairs (0,1),(2,3).. and odd pairs (1,2)..
// Optional macro EXCHANGE_STAT_EN builds the accepted-swap counter;
// without it accept_count is tied to zero and stat_clear is ignored.
//
// Judge handshake: judge_req is high for the whole ISSUE state with
// judge_pair held stable; a transfer happens on every clock edge where
// judge_req && judge_ack, and judge_accept is only sampled on that edge.
// judge_ack may rise in the same cycle judge_req rises.
module exchange_scheduler
  import replica_pkg::*;
#(
  parameter  int replica_num = 32,
  localparam int PW          = $clog2(replica_num)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cycle_finish,
  output logic                   busy,
  output logic                   round_done,
  output logic                   parity,
  output logic                   judge_req,
  output logic [PW-1:0]          judge_pair,
  input  logic                   judge_ack,
  input  logic                   judge_accept,
  output logic [replica_num-1:0] exchange_en,
  output logic                   overrun,
  input  logic                   stat_clear,
  output logic [EXCH_CNT_W-1:0]  accept_count,
  output exch_state_t            debug_state
);

  exch_state_t            state_q;
  exch_state_t            state_d;
  logic                   parity_q;
  logic [PW-1:0]          pair_q;
  logic [replica_num-1:0] pending_q;
  logic                   overrun_q;
  logic                   handshake;
  logic                   accept_hit;
  logic                   last_pair;
  logic [PW:0]            pair_next_wide;

  // One extra bit so the step past the last pair cannot wrap.
  assign pair_next_wide = {1'b0, pair_q} + (PW+1)'(2);
  assign last_pair      = pair_next_wide > (PW+1)'(replica_num - 2);
  assign handshake      = (state_q == EX_ISSUE) && judge_ack;
  assign accept_hit     = handshake && judge_accept;

  // Next-state selection for the round sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EX_IDLE:   if (cycle_finish) state_d = EX_ISSUE;
      EX_ISSUE:  if (judge_ack && last_pair) state_d = EX_COMMIT;
      EX_COMMIT: state_d = EX_IDLE;
      default:   state_d = EX_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pair walker, decision collection and parity alternation.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q  <= 1'b0;
      pair_q    <= '0;
      pending_q <= '0;
    end else begin
      unique case (state_q)
        EX_IDLE: begin
          pair_q    <= {{(PW-1){1'b0}}, parity_q};
          pending_q <= '0;
        end
        EX_ISSUE: begin
          if (judge_ack) begin
            pending_q[pair_q] <= judge_accept;
            pair_q            <= pair_next_wide[PW-1:0];
          end
        end
        EX_COMMIT: begin
          parity_q <= ~parity_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky flag for a cycle_finish that arrives while a round is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (cycle_finish && (state_q != EX_IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign busy        = (state_q != EX_IDLE);
  assign judge_req   = (state_q == EX_ISSUE);
  assign judge_pair  = pair_q;
  assign round_done  = (state_q == EX_COMMIT);
  assign exchange_en = round_done ? pending_q : '0;
  assign parity      = parity_q;
  assign overrun     = overrun_q;
  assign debug_state = state_q;

`ifdef EXCHANGE_STAT_EN
  exchange_stat u_stat (
    .clk   (clk),
    .reset (reset),
    .clear (stat_clear),
    .inc   (accept_hit),
    .count (accept_count)
  );
`else
  logic unused_stat;
  assign unused_stat  = stat_clear ^ accept_hit;
  assign accept_count = '0;
`endif

endmodule

// File: tb/tb_exchange_scheduler.sv
// Bench for exchange_scheduler with 8 replicas: directed rounds, a
// queue-based round model compared every cycle, and literal checks.
module tb_exchange_scheduler;
  import replica_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cycle_finish = 1'b0;
  logic        judge_ack = 1'b0;
  logic        judge_accept = 1'b0;
  logic        stat_clear = 1'b0;
  logic        busy, round_done, parity, judge_req, overrun;
  logic [2:0]  judge_pair;
  logic [N-1:0] exchange_en;
  logic [15:0] accept_count;
  exch_state_t debug_state;

  int total = 0;
  int bad = 0;

  exchange_scheduler #(.replica_num(N)) dut (
    .clk(clk), .reset(reset), .cycle_finish(cycle_finish), .busy(busy),
    .round_done(round_done), .parity(parity), .judge_req(judge_req),
    .judge_pair(judge_pair), .judge_ack(judge_ack), .judge_accept(judge_accept),
    .exchange_en(exchange_en), .overrun(overrun), .stat_clear(stat_clear),
    .accept_count(accept_count), .debug_state(debug_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural round model ----------------
  int       pairs[$];
  bit       commit_now = 0;
  bit [N-1:0] acc = '0;
  bit       m_parity = 0;
  bit       m_overrun = 0;
  int       m_count = 0;
  bit       m_valid = 0;
  int       cyc = 0;
  int       done_cnt = 0;

  always @(posedge clk) begin
    bit busy_now, hs;
    int p;
    cyc++;
    if (reset) begin
      m_valid = 1; pairs.delete(); commit_now = 0; acc = '0;
      m_parity = 0; m_overrun = 0; m_count = 0;
    end else if (m_valid) begin
      busy_now = (pairs.size() != 0) || commit_now;
      hs = (pairs.size() != 0) && judge_ack;
      if (cycle_finish) begin
        if (busy_now) m_overrun = 1;
        else begin
          acc = '0;
          for (int q = int'(m_parity); q <= N - 2; q += 2) pairs.push_back(q);
        end
      end
      if (commit_now) begin
        commit_now = 0;
        m_parity = ~m_parity;
      end
      if (hs) begin
        p = pairs.pop_front();
        if (judge_accept) begin
          acc[p] = 1'b1;
          if (m_count < 65535) m_count++;
        end
        if (pairs.size() == 0) commit_now = 1;
      end
      if (stat_clear) m_count = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    logic [31:0] e_cnt;
    exch_state_t e_st;
    @(posedge clk);
    #1;
    if (m_valid) begin
`ifdef EXCHANGE_STAT_EN
      e_cnt = m_count;
`else
      e_cnt = 0;
`endif
      e_st = commit_now ? EX_COMMIT : ((pairs.size() != 0) ? EX_ISSUE : EX_IDLE);
      chk("busy", busy, (pairs.size() != 0) || commit_now);
      chk("judge_req", judge_req, pairs.size() != 0);
      if (pairs.size() != 0) chk("judge_pair", judge_pair, pairs[0]);
      chk("round_done", round_done, commit_now);
      chk("exchange_en", exchange_en, commit_now ? acc : '0);
      chk("parity", parity, m_parity);
      chk("overrun", overrun, m_overrun);
      chk("accept_count", accept_count, e_cnt);
      chk("debug_state", debug_state, e_st);
      if (round_done) done_cnt++;
    end
  end

  // ---------------- judge responder ----------------
  bit acc_q[$];
  int seen_q[$];
  int stall_pair = -1;
  int stall_left = 0;

  always @(negedge clk) begin
    if (judge_req === 1'b1) begin
      if (stall_left > 0 && int'(judge_pair) == stall_pair) begin
        judge_ack = 0; judge_accept = 0; stall_left--;
      end else begin
        judge_ack = 1;
        judge_accept = (acc_q.size() != 0) ? acc_q.pop_front() : 1'b0;
        seen_q.push_back(int'(judge_pair));
      end
    end else begin
      judge_ack = 0; judge_accept = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_round(output int st);
    @(negedge clk) cycle_finish = 1;
    @(posedge clk);
    #1 st = cyc;
    @(negedge clk) cycle_finish = 0;
  endtask

  task automatic wait_commit(output int cc, output logic [N-1:0] en);
    cc = -1; en = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (round_done === 1'b1) begin
        cc = cyc; en = exchange_en;
        return;
      end
    end
    chk("commit_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_seen(input string name, input int exp[$]);
    chk({name, "_count"}, seen_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen_q.size(); i++)
      chk(name, seen_q[i], exp[i]);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int st, cc, nd;
    logic [N-1:0] en;

    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", judge_req, 0);
    chk("rst_en", exchange_en, 0);
    chk("rst_parity", parity, 0);
    chk("rst_count", accept_count, 0);
    @(negedge clk) reset = 0;
    idle_cycles(2);

    // S1: even round, accepts 1,0,1,1
    acc_q = '{1, 0, 1, 1}; seen_q.delete();
    start_round(st);
    wait_commit(cc, en);
    check_seen("s1_pairs", '{0, 2, 4, 6});
    chk("s1_en", en, 8'h51);
    chk("s1_latency", cc - st, 4);
    idle_cycles(1);
    chk("s1_busy_fall", busy, 0);
    chk("s1_parity", parity, 1);

    // S2: odd round, accepts 1,1,0
    acc_q = '{1, 1, 0}; seen_q.delete();
    start_round(st);
    wait_commit(cc, en);
    check_seen("s2_pairs", '{1, 3, 5});
    chk("s2_en", en, 8'h0A);
    chk("s2_latency", cc - st, 3);
    idle_cycles(1);
    chk("s2_parity", parity, 0);
`ifdef EXCHANGE_STAT_EN
    chk("s2_count", accept_count, 5);
`else
    chk("s2_count", accept_count, 0);
`endif
    @(negedge clk) stat_clear = 1;
    @(negedge clk) stat_clear = 0;
    idle_cycles(1);
    chk("clear_count", accept_count, 0);

    // S4: even round with cycle_finish during ISSUE
    acc_q = '{0, 1, 1, 0}; seen_q.delete();
    start_round(st);
    @(negedge clk) cycle_finish = 1;
    @(negedge clk) cycle_finish = 0;
    wait_commit(cc, en);
    chk("s4_en", en, 8'h14);
    chk("s4_latency", cc - st, 4);
    nd = done_cnt;
    idle_cycles(6);
    chk("s4_overrun", overrun, 1);
    chk("s4_no_restart", busy, 0);
    chk("s4_one_commit", done_cnt, nd);
    chk("s4_parity", parity, 1);

    // S5: reset in the middle of an odd round
    acc_q = '{1, 1, 1}; seen_q.delete();
    start_round(st);
    idle_cycles(1);
    nd = done_cnt;
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_req", judge_req, 0);
    chk("s5_parity", parity, 0);
    chk("s5_overrun", overrun, 0);
    @(negedge clk) reset = 0;
    idle_cycles(6);
    chk("s5_no_commit", done_cnt, nd);

    // S3: ack held low for 3 cycles on pair 2, then cycle_finish in COMMIT
    acc_q.delete(); acc_q = '{0, 0, 0, 0}; seen_q.delete();
    stall_pair = 2; stall_left = 3;
    start_round(st);
    wait_commit(cc, en);
    chk("s3_latency", cc - st, 7);
    chk("s3_en", en, 8'h00);
    @(negedge clk) cycle_finish = 1;
    @(negedge clk) cycle_finish = 0;
    idle_cycles(4);
    chk("s3_commit_overrun", overrun, 1);
    chk("s3_no_restart", busy, 0);
    chk("s3_parity", parity, 1);

`ifdef EXCHANGE_STAT_EN
    // Saturation: preload close to the top, then accept three more.
    @(negedge clk);
    dut.u_stat.count = 16'hFFFD;
    m_count = 65533;
    acc_q = '{1, 1, 1}; seen_q.delete();
    start_round(st);
    wait_commit(cc, en);
    idle_cycles(2);
    chk("sat_count", accept_count, 16'hFFFF);
`endif

    idle_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exchange_scheduler.md
# exchange_scheduler

Replica-exchange sequencer for the parallel-tempering salesman array. After every annealing cycle, triggered by `cycle_finish` from the per-node controller, it walks the neighbouring replica pairs of the current parity one at a time. Each pair goes to the shared Metropolis judge unit over a req/ack handshake. The accept decisions are collected into a single-cycle swap-enable vector that the replica array applies. The scheduler alternates even and odd pair sets between rounds.

## Interface

Parameters:
- `replica_num`, 32, number of replicas; must be even and ≥ 4.
- `PW`, `$clog2(replica_num)`, width of a pair index (derived, not overridden).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `cycle_finish`  in  1  one-cycle pulse that starts an exchange round
- `busy`  out  1  high while a round is in progress
- `round_done`  out  1  one-cycle pulse, coincident with `exchange_en`
- `parity`  out  1  parity of the next/current round: 0 = pairs (0,1),(2,3)…; 1 = pairs (1,2),(3,4)…
- `judge_req`  out  1  request to the shared judge
- `judge_pair`  out  PW  lower replica index i of pair (i, i+1); stable while `judge_req` is high
- `judge_ack`  in  1  judge accepted the request and result is valid; may be asserted in the same cycle as `judge_req`
- `judge_accept`  in  1  swap decision; sampled only when `judge_req && judge_ack`
- `exchange_en`  out  replica_num  bit i = swap replicas i and i+1; non-zero only in the COMMIT cycle; bit replica_num-1 is always 0
- `overrun`  out  1  sticky; set when `cycle_finish` arrives while `busy`
- `stat_clear`  in  1  clears `accept_count`
- `accept_count`  out  16  saturating count of accepted swaps

## Operation

States: IDLE, ISSUE, COMMIT.

- **IDLE**
  - `cycle_finish` → ISSUE.
  - `pair` loads `parity` (0 or 1); the `pending` vector is cleared.
- **ISSUE**
  - `judge_req` = 1 and `judge_pair` = `pair`.
  - On `judge_ack`: `pending[pair]` <= `judge_accept`, and `pair` <= `pair` + 2.
  - If `pair` + 2 > replica_num - 2, the next state is COMMIT.
  - Without `judge_ack`: hold the state, with req and pair held stable.
- **COMMIT** (one cycle)
  - `exchange_en` = `pending` and `round_done` = 1.
  - `parity` toggles at the end of the cycle; next state is IDLE.

Other rules:
- `busy` = (state != IDLE).
- Pairs per round: replica_num/2 for even parity, replica_num/2 - 1 for odd parity.
- `cycle_finish` while `busy` is ignored for sequencing and sets `overrun`, which is cleared only by `reset`.
- `cycle_finish` in the COMMIT cycle counts as busy: it sets `overrun` and does not start a round.
- Reset at any time:
  - state = IDLE, `parity` = 0, `pending` = 0, `overrun` = 0, `accept_count` = 0.
  - All outputs are 0 the cycle after reset is sampled.
- `accept_count`:
  - Increments by 1 per accepted handshake and saturates at 16'hFFFF.
  - `stat_clear` has priority over an increment in the same cycle.

## Timing

- `cycle_finish` at cycle t → `busy` and `judge_req` high at t+1.
- With `judge_ack` always high, a round of N pairs issues during t+1 … t+N; COMMIT (`exchange_en`, `round_done`) is at t+N+1 and `busy` falls at t+N+2.
- Each cycle `judge_ack` is low adds exactly one cycle of latency.
- `exchange_en`, `round_done` and `busy` are registered state decodes with no combinational path from inputs.
- `judge_req` and `judge_pair` are driven from registers only.
- Earliest next round: `cycle_finish` at t+N+2.

## Configuration

- **`EXCHANGE_STAT_EN` defined:** the `accept_count` logic is present, behaving as described above.
- **`EXCHANGE_STAT_EN` not defined:**
  - The counter is not built and `accept_count` is tied to 0.
  - `stat_clear` is ignored.
  - All other behaviour is identical.

## Structure

- `replica_pkg` gains:
  - `exch_state_t` enum {EX_IDLE, EX_ISSUE, EX_COMMIT};
  - constant `EXCH_CNT_W` = 16.
- One sub-module, `exchange_stat`: the 16-bit saturating counter with clear, instantiated under `EXCHANGE_STAT_EN`.

## Test plan

All scenarios use replica_num = 8.

1. Even round, ack always high, accepts 1,0,1,1 → `judge_pair` sequence 0,2,4,6; `exchange_en` = 8'h51 at t+5; `parity` becomes 1.
2. Following odd round, accepts 1,1,0 → pairs 1,3,5; `exchange_en` = 8'h0A at t+4; `parity` back to 0.
3. Ack held low 3 cycles on pair 2 → `judge_pair` stays 2 for 3 extra cycles; COMMIT delayed by exactly 3 cycles.
4. `cycle_finish` pulsed during ISSUE → `overrun` = 1 and stays set; the round completes normally and no second round starts.
5. `reset` during ISSUE → next cycle `busy` = 0, `judge_req` = 0, `parity` = 0; no `exchange_en` pulse.
6. With `EXCHANGE_STAT_EN`: scenarios 1 and 2 give `accept_count` = 5; `stat_clear` → 0. Preloaded near 16'hFFFF plus more accepts → holds at 16'hFFFF. Without the macro the count reads 0.
